// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: sequential RV32I encoder that writes encoded words into instruction memory
module rv_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] count,
  output logic        full
);
  typedef enum logic [1:0] {IDLE, LATCH, ENC, WRITE} state_t;
  state_t state, state_nx;
  logic [4:0] op_q, rd_q, rs1_q, rs2_q;
  logic [31:0] imm_q, word;
  logic [1:0] chk, chk_q;
  logic [2:0] f3;
  logic [6:0] opc, f7;
  logic is_r, is_i, is_s, is_b, is_j, is_u, fits12, fits13, fits21;
  assign is_r = op_q <= 5'd4;
  assign is_i = (op_q >= 5'd5 && op_q <= 5'd9) || op_q == 5'd11;
  assign is_s = op_q == 5'd10;
  assign is_j = op_q == 5'd12;
  assign is_b = op_q >= 5'd13 && op_q <= 5'd16;
  assign is_u = op_q == 5'd17;
  always_comb begin
    f3 = 3'b000;
    case (op_q)
      5'd2:                     f3 = 3'b111;
      5'd3, 5'd7:               f3 = 3'b110;
      5'd4, 5'd8, 5'd9, 5'd10:  f3 = 3'b010;
      5'd6, 5'd15:              f3 = 3'b100;
      5'd14:                    f3 = 3'b001;
      5'd16:                    f3 = 3'b101;
      default:                  f3 = 3'b000;
    endcase
  end
  assign opc = is_r ? 7'b0110011 : op_q == 5'd9 ? 7'b0000011 : op_q == 5'd11 ? 7'b1100111 :
               is_i ? 7'b0010011 : is_s ? 7'b0100011 : is_b ? 7'b1100011 :
               is_j ? 7'b1101111 : 7'b0110111;
  assign f7 = op_q == 5'd1 ? 7'b0100000 : 7'b0000000;
  assign word = is_r ? {f7, rs2_q, rs1_q, f3, rd_q, opc} :
                is_i ? {imm_q[11:0], rs1_q, f3, rd_q, opc} :
                is_s ? {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], opc} :
                is_b ? {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3, imm_q[4:1], imm_q[11], opc} :
                is_j ? {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opc} :
                       {imm_q[31:12], rd_q, opc};
  // a signed value fits in N bits when all bits above N-1 equal the sign bit
  assign fits12 = &imm_q[31:11] || ~|imm_q[31:11];
  assign fits13 = &imm_q[31:12] || ~|imm_q[31:12];
  assign fits21 = &imm_q[31:20] || ~|imm_q[31:20];
  assign chk = op_q > 5'd17 ? 2'd1 :
               (((is_b || is_j) && imm_q[0]) || (is_u && |imm_q[11:0])) ? 2'd3 :
               (((is_i || is_s) && !fits12) || (is_b && !fits13) || (is_j && !fits21)) ? 2'd2 : 2'd0;
  assign full = count == 16'(DEPTH);
  assign in_ready = state == IDLE && !full;
  assign imem_we = state == WRITE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid && in_ready ? LATCH : IDLE;
      LATCH:   state_nx = ENC;
      ENC:     state_nx = chk_q == 2'd0 ? WRITE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst || clear) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_addr <= BASE_ADDR;
      imem_wdata <= '0;
      err <= 1'b0;
      err_code <= 2'd0;
      count <= '0;
      chk_q <= 2'd0;
    end else if (clear) begin
      imem_addr <= BASE_ADDR;
      err <= 1'b0;
      err_code <= 2'd0;
      count <= '0;
    end else begin
      if (state == IDLE && in_valid && in_ready) begin
        op_q <= op_sel;
        rd_q <= rd;
        rs1_q <= rs1;
        rs2_q <= rs2;
        imm_q <= imm;
      end
      if (state == LATCH) begin
        imem_wdata <= word;
        chk_q <= chk;
      end
      if (state == ENC && chk_q != 2'd0 && !err) begin
        err <= 1'b1;
        err_code <= chk_q;
      end
      if (state == WRITE) begin
        imem_addr <= imem_addr + 32'd4;
        count <= count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb_rv_instr_encoder: randomized and directed checks of rv_instr_encoder against a field-level model
module tb_rv_instr_encoder;
  logic clk = 0, rst = 1, clear = 0, rst2 = 1, clear2 = 0, in_valid = 0;
  logic [4:0] op_sel = 0, rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0;
  logic in_ready, imem_we, err, full, in_ready2, we2, err2, full2;
  logic [31:0] imem_addr, imem_wdata, addr2, wdata2;
  logic [1:0] err_code, code2;
  logic [15:0] count, count2;
  int ncmp = 0, nfail = 0;
  logic [31:0] m_addr = 0, obs_wdata;
  int m_count = 0, m_code = 0;
  logic m_err = 0;
  int opc_t[18] = '{'h33, 'h33, 'h33, 'h33, 'h33, 'h13, 'h13, 'h13, 'h13, 'h03, 'h23, 'h67, 'h6F, 'h63, 'h63, 'h63, 'h63, 'h37};
  int f3_t[18]  = '{0, 0, 7, 6, 2, 0, 4, 6, 2, 2, 2, 0, 0, 0, 1, 4, 5, 0};
  int fmt_t[18] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 1, 4, 3, 3, 3, 3, 5};

  rv_instr_encoder dut (.clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .err(err), .err_code(err_code), .count(count), .full(full));
  rv_instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(2)) dut2 (.clk(clk), .rst(rst2), .clear(clear2),
    .in_valid(in_valid), .in_ready(in_ready2), .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2), .err(err2), .err_code(code2), .count(count2),
    .full(full2));

  always #5 clk = ~clk;

  // fmt: 0 R, 1 I, 2 S, 3 B, 4 J, 5 U
  function automatic void ref_model(input int op, input logic [4:0] d, s1, s2, input logic [31:0] im,
                                    output logic [31:0] w, output int code);
    int si, f;
    si = $signed(im);
    w = 0;
    code = 0;
    if (op > 17) begin
      code = 1;
      return;
    end
    f = fmt_t[op];
    if (((f == 3 || f == 4) && im[0]) || (f == 5 && (im & 32'hFFF) != 0)) code = 3;
    else if (((f == 1 || f == 2) && (si < -2048 || si > 2047)) || (f == 3 && (si < -4096 || si > 4094)) ||
             (f == 4 && (si < -1048576 || si > 1048574))) code = 2;
    w = 32'(opc_t[op]) | (32'(f3_t[op]) << 12);
    case (f)
      0: w |= (op == 1 ? 32'h4000_0000 : 0) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(d) << 7);
      1: w |= ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(d) << 7);
      2: w |= (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | ((im & 32'h1F) << 7);
      3: w |= (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) |
              (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7);
      4: w |= (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20) |
              (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7);
      default: w |= (im & 32'hFFFF_F000) | (32'(d) << 7);
    endcase
  endfunction

  task automatic do_instr(input int op, input logic [4:0] d, s1, s2, input logic [31:0] im);
    logic [31:0] w;
    int code, n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ncmp++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL ready_timeout: in_ready=%b want 1", in_ready);
      return;
    end
    ref_model(op, d, s1, s2, im, w, code);
    op_sel = 5'(op); rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    ncmp++;
    if ({imem_we, in_ready} !== 2'b00) begin
      nfail++;
      $display("FAIL latch_phase: we,ready=%b want 00", {imem_we, in_ready});
    end
    @(negedge clk);
    ncmp++;
    if ({imem_we, in_ready} !== 2'b00) begin
      nfail++;
      $display("FAIL enc_phase: we,ready=%b want 00", {imem_we, in_ready});
    end
    @(negedge clk);
    obs_wdata = imem_wdata;
    ncmp++;
    if (imem_we !== (code == 0)) begin
      nfail++;
      $display("FAIL write_strobe op=%0d imm=%h: we=%b want %b", op, im, imem_we, code == 0);
    end
    if (code == 0) begin
      ncmp++;
      if (imem_addr !== m_addr || imem_wdata !== w || in_ready !== 1'b0) begin
        nfail++;
        $display("FAIL write_data op=%0d imm=%h: addr=%h data=%h ready=%b want addr=%h data=%h ready=0",
                 op, im, imem_addr, imem_wdata, in_ready, m_addr, w);
      end
      m_addr += 4;
      m_count++;
    end else if (!m_err) begin
      m_err = 1;
      m_code = code;
    end
    @(negedge clk);
    ncmp++;
    if (imem_we !== 1'b0 || imem_addr !== m_addr || count !== 16'(m_count) || err !== m_err ||
        err_code !== 2'(m_code) || in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL post_state op=%0d: we=%b addr=%h count=%0d err=%b code=%0d ready=%b want 0 %h %0d %b %0d 1",
               op, imem_we, imem_addr, count, err, err_code, in_ready, m_addr, m_count, m_err, m_code);
    end
  endtask

  task automatic test_reset();
    rst = 1; rst2 = 1;
    repeat (2) @(negedge clk);
    rst = 0; rst2 = 0;
    m_addr = 0; m_count = 0; m_err = 0; m_code = 0;
    ncmp++;
    if ({in_ready, imem_we, err, full} !== 4'b1000 || imem_addr !== 0 || imem_wdata !== 0 ||
        err_code !== 0 || count !== 0) begin
      nfail++;
      $display("FAIL reset: ready,we,err,full=%b addr=%h data=%h code=%0d count=%0d want 1000 0 0 0 0",
               {in_ready, imem_we, err, full}, imem_addr, imem_wdata, err_code, count);
    end
  endtask

  task automatic test_directed();
    logic [31:0] exp_w[6] = '{32'h00500093, 32'hFFC0A203, 32'h0020A423, 32'h123452B7, 32'hFE208EE3, 32'h008000EF};
    int ops[6] = '{5, 9, 10, 17, 13, 12};
    logic [4:0] ds[6] = '{1, 4, 0, 5, 0, 1};
    logic [4:0] s1s[6] = '{0, 1, 1, 0, 1, 0};
    logic [4:0] s2s[6] = '{0, 0, 2, 0, 2, 0};
    logic [31:0] ims[6] = '{5, 32'hFFFF_FFFC, 8, 32'h1234_5000, 32'hFFFF_FFFC, 8};
    for (int i = 0; i < 6; i++) begin
      do_instr(ops[i], ds[i], s1s[i], s2s[i], ims[i]);
      ncmp++;
      if (obs_wdata !== exp_w[i]) begin
        nfail++;
        $display("FAIL directed_%0d: data=%h want %h", i, obs_wdata, exp_w[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0;
    a0 = m_addr;
    do_instr(0, 3, 1, 2, 0);
    ncmp++;
    if (obs_wdata !== 32'h002081B3) begin
      nfail++;
      $display("FAIL b2b_add: data=%h want 002081b3", obs_wdata);
    end
    do_instr(1, 3, 1, 2, 0);
    ncmp++;
    if (obs_wdata !== 32'h402081B3 || imem_addr !== a0 + 8) begin
      nfail++;
      $display("FAIL b2b_sub: data=%h addr=%h want 402081b3 %h", obs_wdata, imem_addr, a0 + 8);
    end
  endtask

  task automatic test_errors();
    logic [31:0] a0;
    a0 = m_addr;
    do_instr(13, 0, 1, 2, 3);
    ncmp++;
    if (err !== 1'b1 || err_code !== 2'd3 || imem_addr !== a0) begin
      nfail++;
      $display("FAIL err_misalign: err=%b code=%0d addr=%h want 1 3 %h", err, err_code, imem_addr, a0);
    end
    do_instr(5, 1, 0, 0, 4096);
    ncmp++;
    if (err_code !== 2'd3 || imem_addr !== a0) begin
      nfail++;
      $display("FAIL err_sticky: code=%0d addr=%h want 3 %h", err_code, imem_addr, a0);
    end
    do_instr(5, 2, 0, 0, 7);
    ncmp++;
    if (obs_wdata !== 32'h00700113 || imem_addr !== a0 + 4) begin
      nfail++;
      $display("FAIL err_recover: data=%h addr=%h want 00700113 %h", obs_wdata, imem_addr, a0 + 4);
    end
  endtask

  task automatic test_random();
    logic [31:0] bnd[14] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098, 1048574, 1048576,
                             -1048576, -1048578, 32'h1234_5000, 1};
    logic [31:0] im;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: im = 32'($urandom_range(0, 64)) - 32;
        1: im = bnd[$urandom_range(0, 13)];
        2: im = $urandom;
        default: im = (32'($urandom_range(0, 4000)) - 2000) & ~32'h1;
      endcase
      do_instr($urandom_range(0, 19), 5'($urandom), 5'($urandom), 5'($urandom), im);
    end
  endtask

  task automatic test_full();
    clear2 = 1;
    @(negedge clk);
    clear2 = 0;
    do_instr(20, 0, 0, 0, 0);
    do_instr(5, 1, 0, 0, 1);
    do_instr(6, 2, 1, 0, 3);
    ncmp++;
    if ({full2, in_ready2, err2} !== 3'b101 || count2 !== 2 || addr2 !== 8 || code2 !== 1) begin
      nfail++;
      $display("FAIL full: full,ready,err=%b count=%0d addr=%h code=%0d want 101 2 8 1",
               {full2, in_ready2, err2}, count2, addr2, code2);
    end
    clear2 = 1;
    @(negedge clk);
    clear2 = 0;
    ncmp++;
    if ({full2, in_ready2, err2} !== 3'b010 || count2 !== 0 || addr2 !== 0 || code2 !== 0) begin
      nfail++;
      $display("FAIL clear: full,ready,err=%b count=%0d addr=%h code=%0d want 010 0 0 0",
               {full2, in_ready2, err2}, count2, addr2, code2);
    end
  endtask

  task automatic test_rst_mid();
    op_sel = 5; rd = 1; rs1 = 0; rs2 = 0; imm = 9; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_addr = 0; m_count = 0; m_err = 0; m_code = 0;
    ncmp++;
    if (imem_we !== 1'b0 || in_ready !== 1'b1 || count !== 0 || imem_addr !== 0) begin
      nfail++;
      $display("FAIL rst_mid: we=%b ready=%b count=%0d addr=%h want 0 1 0 0", imem_we, in_ready, count, imem_addr);
    end
    do_instr(5, 1, 0, 0, 9);
    op_sel = 3; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    clear = 1;
    @(negedge clk);
    clear = 0;
    m_addr = 0; m_count = 0;
    for (int i = 0; i < 3; i++) begin
      ncmp++;
      if (imem_we !== 1'b0 || count !== 0 || imem_addr !== 0) begin
        nfail++;
        $display("FAIL clear_mid_%0d: we=%b count=%0d addr=%h want 0 0 0", i, imem_we, count, imem_addr);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_errors();
    test_random();
    test_full();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Sequential RV32I instruction encoder and program loader. It accepts one symbolic instruction per handshake (mnemonic select, register indices, signed immediate) and builds the 32-bit machine word.
- The word uses the opcode, funct3 and funct7 values our single-cycle core's controller decodes. The encoder writes each word into instruction memory at consecutive word addresses.
- It sits between the testbench/boot loader and the core's instruction memory write port, and lets us generate programs without hand-assembled hex.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written.
- DEPTH, 256, maximum number of words written before the block reports full.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous restart: address back to BASE_ADDR, counters and error cleared; no effect on the state machine if rst is high.
- in_valid  in  1  symbolic instruction present.
- in_ready  out  1  encoder can accept.
- op_sel  in  5  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 XORI, 7 ORI, 8 SLTI, 9 LW, 10 SW, 11 JALR, 12 JAL, 13 BEQ, 14 BNE, 15 BLT, 16 BGE, 17 LUI; 18-31 invalid.
- rd, rs1, rs2  in  5 each  register indices; unused fields are ignored.
- imm  in  32  signed immediate. For LUI it is the full 32-bit value.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  32  byte address of the word being written.
- imem_wdata  out  32  encoded instruction.
- err  out  1  sticky error flag.
- err_code  out  2  1 = invalid op_sel, 2 = immediate out of range, 3 = misaligned immediate; holds the first error.
- count  out  16  number of words written since reset/clear.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (rst=1 at edge) values:
  - state IDLE; in_ready=1 unless full.
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - err=0, err_code=0, count=0, full=0.
- FSM:
  - IDLE -> LATCH on in_valid&&in_ready. LATCH registers op_sel, rd, rs1, rs2, imm.
  - LATCH -> ENC: compute the word and run the checks.
  - ENC -> WRITE if the checks pass; ENC -> IDLE with the error set if they fail. A failed instruction writes nothing and does not advance the address.
  - WRITE: imem_we=1 for exactly one cycle with the current imem_addr/imem_wdata. On leaving WRITE, imem_addr+=4 and count+=1, then -> IDLE.
  - in_ready=1 only in IDLE and when full=0. Throughput is one word per 4 cycles. Handshake to imem_we asserted is 3 cycles.
  - in_valid while in_ready=0 is ignored; the producer must hold it.
- Encoding formats:
  - R (ADD/SUB/AND/OR/SLT): opcode 0110011; funct3 000/000/111/110/010; funct7 0000000, except SUB = 0100000.
  - I-ALU: opcode 0010011; funct3 ADDI 000, XORI 100, ORI 110, SLTI 010.
  - LW: opcode 0000011, funct3 010. JALR: opcode 1100111, funct3 000.
  - I-type places imm[11:0] in bits [31:20].
  - SW: opcode 0100011, funct3 010; imm[11:5] in [31:25], imm[4:0] in [11:7].
  - B-type: opcode 1100011; funct3 BEQ 000, BNE 001, BLT 100, BGE 101; bits are imm[12|10:5] and imm[4:1|11].
  - JAL: opcode 1101111; bits imm[20|10:1|11|19:12].
  - LUI: opcode 0110111; imm[31:12] in [31:12].
- Checks, evaluated in priority order 1, 3, 2:
  - op_sel > 17 -> code 1.
  - B or J with imm[0]=1, or LUI with imm[11:0] != 0 -> code 3.
  - Range -> code 2:
    - I/S: -2048..2047.
    - B: -4096..4094.
    - J: -1048576..1048574.
    - R: imm ignored, never an error.
- Error handling:
  - The first error sets err and latches err_code; later errors do not overwrite it.
  - The encoder keeps accepting after an error.
- Full:
  - When count reaches DEPTH, full=1 and in_ready=0 until clear or rst.
  - The address never wraps.
- clear/rst mid-operation:
  - Abandon the in-flight instruction; no write strobe occurs on the cycle after the reset edge.
  - rst has priority over clear.

Test Plan:
- Reset, then ADDI rd=1 rs1=0 imm=5 -> one imem_we pulse 3 cycles after handshake, addr 0x0, data 0x00500093; count=1.
- Back-to-back ADD 3,1,2 then SUB 3,1,2 -> data 0x002081B3 @0x0, 0x402081B3 @0x4; in_ready low 3 cycles between accepts.
- LW rd=4 rs1=1 imm=-4 -> 0xFFC0A203; SW rs1=1 rs2=2 imm=8 -> 0x0020A423; LUI rd=5 imm=0x12345000 -> 0x123452B7.
- BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; JAL rd=1 imm=8 -> 0x008000EF.
- Errors:
  - BEQ imm=3 -> no write, err=1, code 3, address unchanged.
  - Then ADDI imm=4096 -> no write, code stays 3.
  - Then a valid ADDI writes at the same address.
- DEPTH=2: two writes -> full=1, in_ready=0; clear -> addr=BASE_ADDR, count=0, err=0. Assert rst during ENC -> no imem_we.
